// File: rtl/ahblite_keypad_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_keypad_fifo_pkg
// Description : Shared register offsets, bit positions, event layout and
//               scan FSM state type for the AHB-Lite keypad controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ahblite_keypad_fifo_pkg;

  // Register offsets (HADDR[7:0])
  localparam logic [7:0] KP_CTRL   = 8'h00;
  localparam logic [7:0] KP_STATUS = 8'h04;
  localparam logic [7:0] KP_DATA   = 8'h08;
  localparam logic [7:0] KP_STABLE = 8'h0C;

  // CTRL bit positions
  localparam int CTRL_SCAN_EN = 0;
  localparam int CTRL_IRQ_EN  = 1;
  localparam int CTRL_REL_EN  = 2;

  // STATUS bit positions
  localparam int ST_EMPTY   = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVF     = 2;
  localparam int ST_CNT_LSB = 8;
  localparam int ST_CNT_W   = 6;

  // DATA event field positions
  localparam int EV_VALID   = 31;
  localparam int EV_PRESS   = 16;
  localparam int EV_IDX_W   = 6;

  // Scan FSM states
  typedef enum logic [0:0] {
    SCAN_IDLE  = 1'b0,
    SCAN_DRIVE = 1'b1
  } scan_state_t;

endpackage
`default_nettype wire

// File: rtl/ahblite_keypad_fifo_scan_deb.sv
`default_nettype none
// ============================================================================
// Module      : keypad_scan_deb
// Description : Row driver, 2-FF column synchroniser and frame-wise debounce.
//               Emits a one-cycle strobe with the changed-bit mask whenever
//               the debounced key map is updated.
// Revision    : 1.0 - initial release
// ============================================================================
module keypad_scan_deb
  import ahblite_keypad_fifo_pkg::*;
#(
  parameter int ROWS      = 4,
  parameter int COLS      = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int DEB_SCANS = 4
)(
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_scan_en,
  input  logic                 i_emit_busy,
  input  logic [COLS-1:0]      i_col,
  output logic [ROWS-1:0]      o_row,
  output logic [ROWS*COLS-1:0] o_stable_map,
  output logic [ROWS*COLS-1:0] o_chg_mask,
  output logic                 o_stable_upd
);

  localparam int NKEY = ROWS * COLS;
  localparam int RW   = $clog2(ROWS);
  localparam int DW   = $clog2(SCAN_DIV);
  localparam logic [RW-1:0]   C_ROW_LAST = RW'(ROWS - 1);
  localparam logic [DW-1:0]   C_DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      C_DEB      = 4'(DEB_SCANS);
  localparam logic [ROWS-1:0] C_ROW_IDLE = '1;
  localparam logic [ROWS-1:0] C_ROW_ONE  = ROWS'(1);

  scan_state_t     r_state;
  logic [ROWS-1:0] r_row;
  logic [RW-1:0]   r_row_idx;
  logic [DW-1:0]   r_div_cnt;
  logic [COLS-1:0] r_col_s1;
  logic [COLS-1:0] r_col_s2;
  logic [NKEY-1:0] r_frame;
  logic [NKEY-1:0] r_last_frame;
  logic [3:0]      r_match;
  logic [NKEY-1:0] r_stable;
  logic [NKEY-1:0] r_chg;
  logic            r_upd;

  logic [NKEY-1:0] w_frame_full;
  logic [3:0]      w_match_next;
  logic [RW-1:0]   w_idx_next;
  logic [ROWS-1:0] w_row_next;

  // Columns are released-high; synchronise before any use
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_col_s1 <= '1;
      r_col_s2 <= '1;
    end else begin
      r_col_s1 <= i_col;
      r_col_s2 <= r_col_s1;
    end
  end

  // Current frame with this row's pressed columns merged in, plus next-row decode
  always_comb begin
    w_frame_full = r_frame;
    w_frame_full[int'(r_row_idx)*COLS +: COLS] = ~r_col_s2;
    if (w_frame_full == r_last_frame)
      w_match_next = (r_match >= C_DEB) ? C_DEB : r_match + 4'd1;
    else
      w_match_next = 4'd1;
    w_idx_next = (r_row_idx == C_ROW_LAST) ? '0 : r_row_idx + 1'b1;
    w_row_next = ~(C_ROW_ONE << w_idx_next);
  end

  // Scan FSM with frame-end debounce and stable-map update
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= SCAN_IDLE;
      r_row        <= C_ROW_IDLE;
      r_row_idx    <= '0;
      r_div_cnt    <= '0;
      r_frame      <= '0;
      r_last_frame <= '0;
      r_match      <= '0;
      r_stable     <= '0;
      r_chg        <= '0;
      r_upd        <= 1'b0;
    end else begin
      r_upd <= 1'b0;
      case (r_state)
        SCAN_IDLE: begin
          r_row <= C_ROW_IDLE;
          if (i_scan_en) begin
            r_state   <= SCAN_DRIVE;
            r_row_idx <= '0;
            r_div_cnt <= '0;
            r_row     <= ~C_ROW_ONE;
          end
        end
        SCAN_DRIVE: begin
          if (!i_scan_en) begin
            // Partial frame is abandoned; stable map is left untouched
            r_state <= SCAN_IDLE;
            r_row   <= C_ROW_IDLE;
          end else if (r_div_cnt == C_DIV_LAST) begin
            r_div_cnt <= '0;
            r_frame   <= w_frame_full;
            r_row_idx <= w_idx_next;
            r_row     <= w_row_next;
            if (r_row_idx == C_ROW_LAST) begin
              r_last_frame <= w_frame_full;
              r_match      <= w_match_next;
              // An update while events are still being walked would lose them,
              // so it is deferred; the saturated counter retries next frame.
              if (w_match_next == C_DEB && w_frame_full != r_stable && !i_emit_busy) begin
                r_stable <= w_frame_full;
                r_chg    <= w_frame_full ^ r_stable;
                r_upd    <= 1'b1;
              end
            end
          end else begin
            r_div_cnt <= r_div_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= SCAN_IDLE;
          r_row   <= C_ROW_IDLE;
        end
      endcase
    end
  end

  assign o_row        = r_row;
  assign o_stable_map = r_stable;
  assign o_chg_mask   = r_chg;
  assign o_stable_upd = r_upd;

endmodule
`default_nettype wire

// File: rtl/ahblite_keypad_fifo.sv
`default_nettype none
// ============================================================================
// Module      : ahblite_keypad_fifo
// Description : AHB-Lite matrix keypad controller. Debounced key changes are
//               turned into press/release events queued in a FIFO that
//               software drains through a pop-on-read DATA register.
// Revision    : 1.0 - initial release
// ============================================================================
module ahblite_keypad_fifo
  import ahblite_keypad_fifo_pkg::*;
#(
  parameter int ROWS       = 4,
  parameter int COLS       = 4,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_SCANS  = 4,
  parameter int FIFO_DEPTH = 8
)(
  input  logic            HCLK,
  input  logic            HRESET,
  input  logic            HSEL,
  input  logic [31:0]     HADDR,
  input  logic [1:0]      HTRANS,
  input  logic [2:0]      HSIZE,
  input  logic [3:0]      HPROT,
  input  logic            HWRITE,
  input  logic [31:0]     HWDATA,
  input  logic            HREADY,
  output logic            HREADYOUT,
  output logic [31:0]     HRDATA,
  output logic            HRESP,
  input  logic [COLS-1:0] col,
  output logic [ROWS-1:0] row,
  output logic            key_irq
);

  localparam int NKEY = ROWS * COLS;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] C_DEPTH = (AW+1)'(FIFO_DEPTH);

  logic            r_wr_pend;
  logic [7:0]      r_wr_addr;
  logic [2:0]      r_ctrl;
  logic [31:0]     r_hrdata;
  logic            r_irq;
  logic [6:0]      r_mem [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [AW:0]     r_count;
  logic            r_ovf;
  logic [NKEY-1:0] r_emit_mask;
  logic [NKEY-1:0] r_emit_map;

  logic            w_trans_req;
  logic            w_rd;
  logic            w_wr;
  logic [7:0]      w_addr;
  logic            w_empty;
  logic            w_full;
  logic            w_pop;
  logic            w_push;
  logic            w_push_ok;
  logic [5:0]      w_emit_idx;
  logic            w_emit_press;
  logic [NKEY-1:0] w_emit_clr;
  logic [6:0]      w_head;
  logic [31:0]     w_rdata;
  logic [NKEY-1:0] w_stable_map;
  logic [NKEY-1:0] w_chg_mask;
  logic            w_stable_upd;
  logic            w_unused;

  assign w_unused = ^{HADDR[31:8], HSIZE, HPROT, HWDATA[31:3]};

  keypad_scan_deb #(
    .ROWS      (ROWS),
    .COLS      (COLS),
    .SCAN_DIV  (SCAN_DIV),
    .DEB_SCANS (DEB_SCANS)
  ) u_scan (
    .i_clk        (HCLK),
    .i_rst        (HRESET),
    .i_scan_en    (r_ctrl[CTRL_SCAN_EN]),
    .i_emit_busy  (|r_emit_mask),
    .i_col        (col),
    .o_row        (row),
    .o_stable_map (w_stable_map),
    .o_chg_mask   (w_chg_mask),
    .o_stable_upd (w_stable_upd)
  );

  assign w_trans_req = HSEL & HREADY & HTRANS[1];
  assign w_rd        = w_trans_req & ~HWRITE;
  assign w_wr        = w_trans_req & HWRITE;
  assign w_addr      = HADDR[7:0];
  assign w_empty     = (r_count == '0);
  assign w_full      = (r_count == C_DEPTH);
  assign w_head      = r_mem[r_rptr];
  assign w_pop       = w_rd & (w_addr == KP_DATA) & ~w_empty;
  assign w_push      = (|r_emit_mask) & (w_emit_press | r_ctrl[CTRL_REL_EN]);
  assign w_push_ok   = w_push & (~w_full | w_pop);

  // Lowest-index pending change is emitted first
  always_comb begin
    w_emit_idx   = '0;
    w_emit_press = 1'b0;
    w_emit_clr   = '0;
    for (int i = NKEY - 1; i >= 0; i--) begin
      if (r_emit_mask[i]) begin
        w_emit_idx    = 6'(i);
        w_emit_press  = r_emit_map[i];
        w_emit_clr    = '0;
        w_emit_clr[i] = 1'b1;
      end
    end
  end

  // Read data mux; unmapped offsets read as zero
  always_comb begin
    w_rdata = '0;
    case (w_addr)
      KP_CTRL:   w_rdata[2:0] = r_ctrl;
      KP_STATUS: begin
        w_rdata[ST_EMPTY] = w_empty;
        w_rdata[ST_FULL]  = w_full;
        w_rdata[ST_OVF]   = r_ovf;
        w_rdata[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(r_count);
      end
      KP_DATA: begin
        if (!w_empty) begin
          w_rdata[EV_VALID]       = 1'b1;
          w_rdata[EV_PRESS]       = w_head[6];
          w_rdata[EV_IDX_W-1:0]   = w_head[5:0];
        end
      end
      KP_STABLE: w_rdata = 32'(w_stable_map);
      default:   w_rdata = '0;
    endcase
  end

  // Bus address phase latch, CTRL write commit and registered read data
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wr_pend <= 1'b0;
      r_wr_addr <= '0;
      r_ctrl    <= '0;
      r_hrdata  <= '0;
    end else begin
      r_wr_pend <= w_wr;
      r_wr_addr <= w_addr;
      if (r_wr_pend && r_wr_addr == KP_CTRL)
        r_ctrl <= HWDATA[2:0];
      if (w_rd)
        r_hrdata <= w_rdata;
    end
  end

  // Event walker: load changed bits on a stable update, retire one per cycle
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_emit_mask <= '0;
      r_emit_map  <= '0;
    end else if (w_stable_upd) begin
      r_emit_mask <= w_chg_mask;
      r_emit_map  <= w_stable_map;
    end else begin
      r_emit_mask <= r_emit_mask & ~w_emit_clr;
    end
  end

  // FIFO storage; contents beyond count are never observed
  always_ff @(posedge HCLK) begin
    if (w_push_ok)
      r_mem[r_wptr] <= {w_emit_press, w_emit_idx};
  end

  // FIFO pointers, occupancy and sticky overflow
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push_ok) r_wptr <= r_wptr + 1'b1;
      if (w_pop)     r_rptr <= r_rptr + 1'b1;
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_wr_pend && r_wr_addr == KP_STATUS && HWDATA[ST_OVF])
        r_ovf <= 1'b0;
      if (w_push && !w_push_ok)
        r_ovf <= 1'b1;
    end
  end

  // Level interrupt, registered from current FIFO state
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) r_irq <= 1'b0;
    else        r_irq <= r_ctrl[CTRL_IRQ_EN] & (~w_empty | r_ovf);
  end

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign HRDATA    = r_hrdata;
  assign key_irq   = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_ahblite_keypad_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahblite_keypad_fifo
// Description : Scoreboard bench for the keypad controller: a key-matrix
//               model drives the columns, reads queue expected words and a
//               monitor compares HRDATA when each read completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahblite_keypad_fifo;

  localparam int ROWS = 4;
  localparam int COLS = 4;

  logic            HCLK = 1'b0;
  logic            HRESET;
  logic            HSEL;
  logic [31:0]     HADDR;
  logic [1:0]      HTRANS;
  logic [2:0]      HSIZE;
  logic [3:0]      HPROT;
  logic            HWRITE;
  logic [31:0]     HWDATA;
  logic            HREADY;
  logic            HREADYOUT;
  logic [31:0]     HRDATA;
  logic            HRESP;
  logic [COLS-1:0] col;
  logic [ROWS-1:0] row;
  logic            key_irq;

  logic [15:0]     keys;
  int              n_checks = 0;
  int              n_err    = 0;
  logic [31:0]     exp_q[$];
  string           name_q[$];
  logic            mon_valid;

  ahblite_keypad_fifo #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(4), .DEB_SCANS(2), .FIFO_DEPTH(8)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .col(col), .row(row), .key_irq(key_irq)
  );

  always #5 HCLK = ~HCLK;

  // Key matrix: a pressed key pulls its column low while its row is driven low
  always_comb begin
    col = '1;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        if (!row[r] && keys[r*COLS+c]) col[c] = 1'b0;
  end

  // A read completes one cycle after its accepted address phase
  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) mon_valid <= 1'b0;
    else        mon_valid <= HSEL & HREADY & HTRANS[1] & ~HWRITE;
  end

  always @(negedge HCLK) begin
    logic [31:0] e;
    string nm;
    if (mon_valid) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_read: HRDATA=%h with no expectation queued", HRDATA);
      end else begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        if (HRDATA !== e) begin
          n_err++;
          $display("FAIL %s: HRDATA=%h expected %h", nm, HRDATA, e);
        end
      end
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge HCLK);
  endtask

  task automatic bus_read(input logic [7:0] a, input logic [31:0] exp, input string nm);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {24'h0, a};
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge HCLK); #1;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {24'h0, a};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0; HWDATA = d;
    @(posedge HCLK); #1;
  endtask

  initial begin
    int waited;
    HRESET = 1'b1; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'h0; HWRITE = 1'b0; HWDATA = '0; HREADY = 1'b1; keys = '0;
    #1;
    check("reset_row",     32'(row),     32'hF);
    check("reset_irq",     32'(key_irq), 32'h0);
    check("reset_hrdata",  HRDATA,       32'h0);
    check("hreadyout",     32'(HREADYOUT), 32'h1);
    check("hresp",         32'(HRESP),   32'h0);
    cycles(3); #3;
    HRESET = 1'b0;

    bus_read(8'h00, 32'h0, "reset_ctrl");
    bus_read(8'h04, 32'h1, "reset_status_empty");
    bus_read(8'h0C, 32'h0, "reset_stable");
    bus_read(8'h08, 32'h0, "reset_data_empty");
    bus_read(8'h10, 32'h0, "unmapped_read");

    // Key (1,2) held, scan only
    keys[6] = 1'b1;
    bus_write(8'h00, 32'h1);
    cycles(52);
    bus_read(8'h0C, 32'h0000_0040, "stable_bit6");
    bus_read(8'h04, 32'h0000_0100, "status_count1");
    bus_read(8'h08, 32'h8001_0006, "press_1_2");
    bus_read(8'h08, 32'h0,         "pop_empty_after_press");

    // Releases queued when rel_en=1
    bus_write(8'h00, 32'h5);
    keys[6] = 1'b0; cycles(80);
    bus_read(8'h08, 32'h8000_0006, "release_1_2");
    keys[6] = 1'b1; cycles(80);
    keys[6] = 1'b0; cycles(80);
    bus_read(8'h08, 32'h8001_0006, "rel_en_press");
    bus_read(8'h08, 32'h8000_0006, "rel_en_release");
    bus_read(8'h08, 32'h0,         "rel_en_drained");
    // Releases dropped when rel_en=0
    bus_write(8'h00, 32'h1);
    keys[6] = 1'b1; cycles(80);
    keys[6] = 1'b0; cycles(80);
    bus_read(8'h08, 32'h8001_0006, "norel_press");
    bus_read(8'h08, 32'h0,         "norel_no_release");

    // Bounce on key (0,0): one toggle per frame, ends pressed
    bus_write(8'h00, 32'h5);
    for (int i = 0; i < 5; i++) begin
      keys[0] = ~keys[0];
      cycles(16);
    end
    bus_read(8'h04, 32'h1, "bounce_no_event");
    cycles(80);
    bus_read(8'h08, 32'h8001_0000, "bounce_single_press");
    bus_read(8'h08, 32'h0,         "bounce_only_one");
    keys[0] = 1'b0; cycles(80);
    bus_read(8'h08, 32'h8000_0000, "bounce_release");

    // Overflow: 10 events into 8 entries
    keys[5:1] = 5'h1F; cycles(80);
    keys[5:1] = 5'h00; cycles(80);
    bus_read(8'h04, 32'h0000_0806, "ovf_status_full");
    bus_write(8'h04, 32'h4);
    bus_read(8'h04, 32'h0000_0802, "ovf_cleared");
    for (int k = 1; k <= 5; k++)
      bus_read(8'h08, 32'h8001_0000 | 32'(k), "ovf_pop_press");
    for (int k = 1; k <= 3; k++)
      bus_read(8'h08, 32'h8000_0000 | 32'(k), "ovf_pop_release");
    bus_read(8'h04, 32'h1, "ovf_drained");

    // Interrupt
    bus_write(8'h00, 32'h7);
    check("irq_idle_empty", 32'(key_irq), 32'h0);
    keys[6] = 1'b1;
    waited = 0;
    while (!key_irq && waited < 150) begin
      @(negedge HCLK);
      waited++;
    end
    check("irq_rise", 32'(key_irq), 32'h1);
    bus_read(8'h08, 32'h8001_0006, "irq_event");
    cycles(2); #1;
    check("irq_fall_after_drain", 32'(key_irq), 32'h0);
    bus_write(8'h00, 32'h1);
    keys[6] = 1'b0; cycles(80);
    keys[9:7] = 3'b111; cycles(80);
    #1;
    check("irq_masked", 32'(key_irq), 32'h0);
    bus_read(8'h04, 32'h0000_0300, "three_pending");

    // Asynchronous reset mid-scan
    @(posedge HCLK); #3;
    HRESET = 1'b1;
    #1;
    check("arst_row",    32'(row),     32'hF);
    check("arst_hrdata", HRDATA,       32'h0);
    check("arst_irq",    32'(key_irq), 32'h0);
    cycles(2); #3;
    HRESET = 1'b0;
    cycles(100);
    bus_read(8'h04, 32'h1, "post_reset_empty");
    bus_read(8'h00, 32'h0, "post_reset_ctrl");
    bus_read(8'h0C, 32'h0, "post_reset_stable");
    bus_read(8'h08, 32'h0, "post_reset_no_event");
    check("post_reset_row", 32'(row), 32'hF);
    cycles(2);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  // Hard time limit so the run always ends
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
`default_nettype wire
